tx_arbiter: RTL and testbench



---
 rtl/tx_arbiter_if.sv | 26 ++
 rtl/tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_arbiter_if.sv
// Requester / transmitter bundle for tx_arbiter.
// The arbiter uses the slave view; clients and the UART model use the master view.
interface tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           Req;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
  logic [NUM_REQ-1:0]           Grant;
  logic [NUM_REQ-1:0]           Done;
  logic                         Timeout_Err;
  logic [DATA_BITS-1:0]         Tx_Data_Out;
  logic                         Transmit_Start_Out;
  logic                         Tx_Busy_In;
  logic                         Arb_Busy;

  modport slave (
    input  Req, Req_Data, Tx_Busy_In,
    output Grant, Done, Timeout_Err, Tx_Data_Out, Transmit_Start_Out, Arb_Busy
  );

  modport master (
    output Req, Req_Data, Tx_Busy_In,
    input  Grant, Done, Timeout_Err, Tx_Data_Out, Transmit_Start_Out, Arb_Busy
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ
// byte requesters: pick a winner, latch its word, pulse start, follow busy
// to completion and report Done (or Timeout_Err) to the owner.
module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  tx_arbiter_if.slave bus
);
  localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] TIMEOUT_LIM = 4'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_sel, w_sel_nxt;
  logic [IDX_W-1:0]     r_last, w_last_nxt;
  logic [IDX_W-1:0]     w_winner, w_idx;
  logic                 w_found;
  logic [3:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_start, w_start_nxt;
  logic                 r_arb_busy, w_arb_busy_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic [DATA_BITS-1:0] w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = bus.Req_Data[g*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search: first set Req bit starting just after the last owner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = IDX_W'((int'(r_last) + off) % NUM_REQ);
      if (!w_found && bus.Req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a branch that
    // forgets one would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_cnt_inc     = r_cnt + 4'd1;
    w_data_nxt    = r_data;
    w_grant_nxt   = '0;
    w_done_nxt    = '0;
    w_timeout_nxt = 1'b0;
    w_start_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The cycle carrying a Done/Timeout pulse is not a sample cycle, so a
        // held request relaunches one full IDLE cycle after completion.
        if (w_found && (r_done == '0) && !r_timeout) begin
          w_state_nxt = S_LAUNCH;
          w_sel_nxt   = w_winner;
          w_data_nxt  = w_words[w_winner];
          w_grant_nxt = NUM_REQ'(1) << w_winner;
          w_start_nxt = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT_BUSY;
        w_cnt_nxt   = 4'd0;
      end
      S_WAIT_BUSY: begin
        if (bus.Tx_Busy_In) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TIMEOUT_LIM) begin
            w_timeout_nxt = 1'b1;
            w_last_nxt    = r_sel;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        // No timeout here: the transmitter may stall on flow control.
        if (!bus.Tx_Busy_In) begin
          w_done_nxt  = NUM_REQ'(1) << r_sel;
          w_last_nxt  = r_sel;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Busy covers the completion pulse cycle too, and drops the cycle after.
    w_arb_busy_nxt = (w_state_nxt != S_IDLE) || (w_done_nxt != '0) || w_timeout_nxt;
  end

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop sees the
    // values from before the edge, independent of statement order.
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_sel      <= '0;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_cnt      <= 4'd0;
      r_data     <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_timeout  <= 1'b0;
      r_start    <= 1'b0;
      r_arb_busy <= 1'b0;
    end else begin
      r_sel      <= w_sel_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      r_start    <= w_start_nxt;
      r_arb_busy <= w_arb_busy_nxt;
    end
  end

  assign bus.Grant              = r_grant;
  assign bus.Done               = r_done;
  assign bus.Timeout_Err        = r_timeout;
  assign bus.Tx_Data_Out        = r_data;
  assign bus.Transmit_Start_Out = r_start;
  assign bus.Arb_Busy           = r_arb_busy;
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: randomized and directed requesters plus a UART busy
// model, checked every cycle against a transaction-timeline reference.
module tb_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int DATA_BITS    = 8;
  localparam int BUSY_TIMEOUT = 4;

  localparam int RM_DIRECTED = 0;
  localparam int RM_HOLD     = 1;
  localparam int RM_RANDOM   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

  tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_BITS   (DATA_BITS),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  // Driven stimulus
  logic [NUM_REQ-1:0]   req_q;
  logic [DATA_BITS-1:0] data_q [NUM_REQ];
  logic                 busy_q;

  assign bus.Req        = req_q;
  assign bus.Tx_Busy_In = busy_q;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign bus.Req_Data[g*DATA_BITS +: DATA_BITS] = data_q[g];
  end

  // Scenario knobs
  int req_mode;
  int frame_fixed;  // <0 selects a random frame length, 0 means never busy
  bit idle_noise;

  // Reference timeline: one transaction at a time, as cycle numbers
  int                   cyc;
  int                   m_next_sample;
  int                   m_launch;
  int                   m_end;
  int                   m_frame;
  int                   m_sel;
  int                   m_last;
  bit                   m_to;
  logic [DATA_BITS-1:0] m_txdata;

  // Observed events
  int                   n_grants, n_dones, n_timeouts;
  int                   last_grant_cyc, last_grant_idx, last_done_cyc, last_to_cyc;
  int                   busy_fall_cyc;
  logic [DATA_BITS-1:0] last_grant_data;
  logic                 busy_after_to;
  bit                   prev_grant, prev_done, prev_start, prev_to;
  int                   grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_frame();
    int r;
    if (frame_fixed >= 0) return frame_fixed;
    r = int'($urandom_range(0, 9));
    return r;  // 0 selects a transmitter that never goes busy
  endfunction

  // Reference at each rising edge: arbitration by round-robin rule, then the
  // whole transaction laid out in absolute cycle numbers.
  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_last        = NUM_REQ - 1;
      m_launch      = -1000;
      m_end         = -1000;
      m_to          = 1'b0;
      m_txdata      = '0;
      m_next_sample = cyc + 1;
    end else if (cyc >= m_next_sample) begin
      if (req_q != '0) begin
        w = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          if (w < 0 && req_q[(m_last + off) % NUM_REQ]) w = (m_last + off) % NUM_REQ;
        end
        m_sel    = w;
        m_last   = w;
        m_launch = cyc;
        m_txdata = data_q[w];
        m_frame  = pick_frame();
        m_to     = (m_frame == 0);
        // Busy is high for m_frame cycles starting the cycle after start;
        // Done follows the first low sample, Timeout after BUSY_TIMEOUT waits.
        m_end         = m_to ? (cyc + 1 + BUSY_TIMEOUT) : (cyc + m_frame + 2);
        m_next_sample = m_end + 2;
      end else begin
        m_next_sample = cyc + 1;
      end
    end
  endtask

  task automatic compare();
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << m_sel;
    check("grant",   32'(bus.Grant),              (cyc == m_launch) ? 32'(oh) : 32'd0);
    check("start",   32'(bus.Transmit_Start_Out), 32'(cyc == m_launch));
    check("done",    32'(bus.Done),               (!m_to && cyc == m_end) ? 32'(oh) : 32'd0);
    check("timeout", 32'(bus.Timeout_Err),        32'(m_to && cyc == m_end));
    check("arb_busy", 32'(bus.Arb_Busy),          32'(cyc >= m_launch && cyc <= m_end));
    check("tx_data", 32'(bus.Tx_Data_Out),        32'(m_txdata));
    // Protocol properties, every cycle
    check("grant_onehot0", 32'($onehot0(bus.Grant)), 32'd1);
    check("done_onehot0",  32'($onehot0(bus.Done)),  32'd1);
    check("grant_2cyc", 32'(prev_grant && (bus.Grant != '0)),         32'd0);
    check("done_2cyc",  32'(prev_done && (bus.Done != '0)),           32'd0);
    check("start_2cyc", 32'(prev_start && bus.Transmit_Start_Out),    32'd0);

    if (prev_to) busy_after_to = bus.Arb_Busy;
    if (bus.Grant != '0) begin
      n_grants++;
      last_grant_cyc  = cyc;
      last_grant_data = bus.Tx_Data_Out;
      for (int i = 0; i < NUM_REQ; i++) if (bus.Grant[i]) last_grant_idx = i;
      grant_log.push_back(last_grant_idx);
    end
    if (bus.Done != '0) begin
      n_dones++;
      last_done_cyc = cyc;
    end
    if (bus.Timeout_Err) begin
      n_timeouts++;
      last_to_cyc = cyc;
    end
    prev_grant = (bus.Grant != '0);
    prev_done  = (bus.Done != '0);
    prev_start = bus.Transmit_Start_Out;
    prev_to    = bus.Timeout_Err;
  endtask

  // Inputs for the next edge: transmitter busy window and requester behaviour.
  task automatic drive();
    logic new_busy;
    if (cyc >= m_launch + 1 && cyc <= m_end) new_busy = !m_to && (cyc <= m_launch + m_frame);
    else new_busy = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (busy_q && !new_busy) busy_fall_cyc = cyc;
    busy_q = new_busy;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (cyc == m_launch && i == m_sel) begin
        if (req_mode == RM_HOLD || (req_mode == RM_RANDOM && $urandom_range(0, 1) == 1)) begin
          data_q[i] = 8'($urandom);  // immediate follow-on request
        end else begin
          req_q[i] = 1'b0;
        end
      end else if (req_mode == RM_RANDOM && !req_q[i] && $urandom_range(0, 3) == 0) begin
        req_q[i]  = 1'b1;
        data_q[i] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
    @(negedge clk);
    drive();
  endtask

  // Advance until `n` more events of a kind (0 grant, 1 done, 2 timeout) or budget.
  task automatic wait_event(input int kind, input int n, input int budget, input string tag);
    int base, k, cnt;
    base = (kind == 0) ? n_grants : (kind == 1) ? n_dones : n_timeouts;
    cnt  = base;
    k    = 0;
    while (cnt < base + n && k < budget) begin
      step();
      k++;
      cnt = (kind == 0) ? n_grants : (kind == 1) ? n_dones : n_timeouts;
    end
    check({tag, "_reached"}, 32'(cnt >= base + n), 32'd1);
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    while (cyc <= m_end + 1 && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    req_q = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int c_req, d0, t0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; req_q = '0; busy_q = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) data_q[i] = '0;
    req_mode = RM_DIRECTED; frame_fixed = 3; idle_noise = 1'b0;
    cyc = 0; m_next_sample = 0; m_launch = -1000; m_end = -1000; m_frame = 0;
    m_sel = 0; m_last = NUM_REQ - 1; m_to = 1'b0; m_txdata = '0;
    n_grants = 0; n_dones = 0; n_timeouts = 0; busy_fall_cyc = 0;
    last_grant_cyc = 0; last_grant_idx = 0; last_done_cyc = 0; last_to_cyc = 0;
    last_grant_data = '0; busy_after_to = 1'b1;
    prev_grant = 0; prev_done = 0; prev_start = 0; prev_to = 0;

    // Reset state (all outputs checked each cycle against a cleared timeline)
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single request: requester 1, word A5
    data_q[1] = 8'hA5;
    req_q     = 4'b0010;
    c_req     = cyc;
    wait_event(0, 1, 10, "single_grant");
    check("single_grant_lat", 32'(last_grant_cyc - c_req), 32'd1);
    check("single_grant_idx", 32'(last_grant_idx), 32'd1);
    check("single_data", 32'(last_grant_data), 32'h A5);
    wait_event(1, 1, 30, "single_done");
    check("single_done_lat", 32'(last_done_cyc - busy_fall_cyc), 32'd1);
    wait_quiet(20);

    // Fairness: everyone requesting continuously after reset
    pulse_reset();
    grant_log.delete();
    req_mode    = RM_HOLD;
    frame_fixed = 2;
    for (int i = 0; i < NUM_REQ; i++) data_q[i] = 8'($urandom);
    req_q = 4'b1111;
    wait_event(0, 5, 100, "fair");
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

    // Randomized traffic, random frame lengths, timeouts and idle busy noise
    req_mode    = RM_RANDOM;
    frame_fixed = -1;
    idle_noise  = 1'b1;
    repeat (800) step();
    req_mode   = RM_DIRECTED;
    req_q      = '0;
    idle_noise = 1'b0;
    wait_quiet(100);

    // Timeout: requester 0, transmitter never busy
    frame_fixed = 0;
    req_q       = 4'b0001;
    d0          = n_dones;
    wait_event(2, 1, 30, "to_pulse");
    step();
    check("to_latency", 32'(last_to_cyc - (last_grant_cyc + 1)), 32'(BUSY_TIMEOUT));
    check("to_no_done", 32'(n_dones - d0), 32'd0);
    check("to_busy_fall", 32'(busy_after_to), 32'd0);
    frame_fixed = 2;
    req_q       = 4'b0011;
    wait_event(0, 1, 10, "to_next");
    check("to_next_idx", 32'(last_grant_idx), 32'd1);
    wait_event(0, 1, 20, "to_next2");
    wait_quiet(20);

    // Flow-control stall: busy held for 1000 cycles
    frame_fixed = 1000;
    req_q       = 4'b0100;
    data_q[2]   = 8'h3C;
    d0          = n_dones;
    t0          = n_timeouts;
    wait_event(1, 1, 1100, "stall_done");
    check("stall_no_to", 32'(n_timeouts - t0), 32'd0);
    check("stall_one_done", 32'(n_dones - d0), 32'd1);
    check("stall_data", 32'(bus.Tx_Data_Out), 32'h3C);
    wait_quiet(20);

    // Reset in the middle of WAIT_DONE, then simultaneous 3 and 0
    frame_fixed = 20;
    req_q       = 4'b0010;
    wait_event(0, 1, 10, "rst_grant");
    repeat (4) step();
    rst_n = 1'b0;
    req_q = '0;
    step();
    check("rst_outputs", 32'({bus.Grant, bus.Done, bus.Timeout_Err, bus.Transmit_Start_Out,
                              bus.Arb_Busy, bus.Tx_Data_Out}), 32'd0);
    rst_n       = 1'b1;
    frame_fixed = 2;
    req_q       = 4'b1001;
    wait_event(0, 1, 10, "rst_next");
    check("rst_next_idx", 32'(last_grant_idx), 32'd0);
    wait_event(0, 1, 20, "rst_next2");
    check("rst_next2_idx", 32'(last_grant_idx), 32'd3);
    wait_quiet(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
